// File: rtl/prob_node_max_exp.sv
// prob_node_max_exp
//   Running maximum exponent over all lines of one probabilistic-circuit node.
//   Each accepted line has its lane exponents pulled out according to the
//   selected float format. A registered compare tree reduces the line (S1),
//   and the result is folded into a node accumulator (S2). The node maximum is
//   then offered on a ready/valid pair to the normalisation stage.
//
//   Optional build macro: MAX_EXP_MIN_TRACK_EN
//     Adds min_exp, the minimum non-zero exponent of the node, which is valid
//     together with max_exp.
//
// Ports
//   clk            clock
//   rst            asynchronous reset, active low
//   mode[1:0]      00 bf16 [14:7], 01 fp16 [14:10], 10 raw [EW-1:0], 11 as 00
//   lines_minus1   node length minus one, sampled on the first beat
//   in_data        LANES words, lane i = in_data[i*DW +: DW]
//   in_vld         line valid
//   in_ready       line accepted when in_vld & in_ready
//   max_exp        node maximum exponent (held until the next result)
//   max_exp_vld    result valid
//   max_exp_ready  downstream takes the result
//   min_exp        (MAX_EXP_MIN_TRACK_EN only) node minimum non-zero exponent
//
// state  | meaning
// IDLE   | waiting for the first beat of a node
// ACCUM  | accepting the remaining beats, counting against lines_minus1
// DRAIN  | last beat taken, letting the compare pipeline empty
// HOLD   | result presented, waiting for max_exp_ready
module prob_node_max_exp #(
  parameter int LANES = 8,
  parameter int DW    = 16,
  parameter int EW    = 8,
  parameter int LW    = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic [LW-1:0]         lines_minus1,
  input  logic [LANES*DW-1:0]   in_data,
  input  logic                  in_vld,
  output logic                  in_ready,
  output logic [EW-1:0]         max_exp,
  output logic                  max_exp_vld,
  input  logic                  max_exp_ready
`ifdef MAX_EXP_MIN_TRACK_EN
  ,
  output logic [EW-1:0]         min_exp
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]          state;
  logic [1:0]          mode_q;
  logic [LW-1:0]       lm1_q;
  logic [LW-1:0]       cnt;
  logic [LW-1:0]       cnt_nxt;
  logic [1:0]          eff_mode;
  logic                accept;
  logic [LANES*EW-1:0] lane_exp;
  logic                s1_vld;
  logic [EW-1:0]       s1_max;
  logic [EW-1:0]       acc;
  logic [EW-1:0]       max_q;

  // Some word bits (e.g. the sign) never feed an exponent.
  logic unused_in;
  assign unused_in = ^in_data;

  function automatic logic [EW-1:0] tree_max(input logic [LANES*EW-1:0] v);
    logic [EW-1:0] t [1:2*LANES-1];
    for (int i = 0; i < LANES; i++) t[LANES+i] = v[i*EW +: EW];
    for (int i = LANES-1; i >= 1; i--) t[i] = (t[2*i+1] > t[2*i]) ? t[2*i+1] : t[2*i];
    return t[1];
  endfunction

  // in_ready comes only from registered state.
  assign in_ready    = (state == S_IDLE) || (state == S_ACCUM);
  assign accept      = in_vld & in_ready;
  assign max_exp_vld = (state == S_HOLD);
  assign max_exp     = max_q;
  assign cnt_nxt     = cnt + 1'b1;
  // The first beat is decoded with the live mode, later beats with the latched one.
  assign eff_mode    = (state == S_IDLE) ? mode : mode_q;

  always_comb begin
    lane_exp = '0;
    for (int i = 0; i < LANES; i++) begin
      case (eff_mode)
        2'b01:   lane_exp[i*EW +: 5]  = in_data[i*DW+10 +: 5];
        2'b10:   lane_exp[i*EW +: EW] = in_data[i*DW +: EW];
        default: lane_exp[i*EW +: 8]  = in_data[i*DW+7 +: 8];
      endcase
    end
  end

`ifdef MAX_EXP_MIN_TRACK_EN
  logic [LANES*EW-1:0] lane_min_in;
  logic                s1_nz;
  logic [EW-1:0]       s1_min;
  logic [EW-1:0]       min_acc;
  logic                min_seen;
  logic [EW-1:0]       min_q;

  function automatic logic [EW-1:0] tree_min(input logic [LANES*EW-1:0] v);
    logic [EW-1:0] t [1:2*LANES-1];
    for (int i = 0; i < LANES; i++) t[LANES+i] = v[i*EW +: EW];
    for (int i = LANES-1; i >= 1; i--) t[i] = (t[2*i+1] < t[2*i]) ? t[2*i+1] : t[2*i];
    return t[1];
  endfunction

  // Zero/denormal lanes become all-ones so that they never win the min.
  always_comb begin
    lane_min_in = lane_exp;
    for (int i = 0; i < LANES; i++)
      if (lane_exp[i*EW +: EW] == '0) lane_min_in[i*EW +: EW] = '1;
  end

  assign min_exp = min_q;

  // min_seen separates "no non-zero lane" from a genuine all-ones exponent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_nz    <= 1'b0;
      s1_min   <= '1;
      min_acc  <= '1;
      min_seen <= 1'b0;
      min_q    <= '0;
    end else begin
      if (accept) begin
        s1_nz  <= |lane_exp;
        s1_min <= tree_min(lane_min_in);
      end
      if (s1_vld && s1_nz) begin
        min_seen <= 1'b1;
        if (s1_min < min_acc) min_acc <= s1_min;
      end
      if (state == S_DRAIN && !s1_vld) min_q <= min_seen ? min_acc : '0;
      if (state == S_HOLD && max_exp_ready) begin
        min_acc  <= '1;
        min_seen <= 1'b0;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      mode_q <= 2'b00;
      lm1_q  <= '0;
      cnt    <= '0;
      s1_vld <= 1'b0;
      s1_max <= '0;
      acc    <= '0;
      max_q  <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) s1_max <= tree_max(lane_exp);
      // Strictly greater: ties keep the existing value.
      if (s1_vld && (s1_max > acc)) acc <= s1_max;
      case (state)
        S_IDLE: if (accept) begin
          mode_q <= mode;
          lm1_q  <= lines_minus1;
          cnt    <= '0;
          state  <= (lines_minus1 == '0) ? S_DRAIN : S_ACCUM;
        end
        S_ACCUM: if (accept) begin
          cnt <= cnt_nxt;
          if (cnt_nxt == lm1_q) state <= S_DRAIN;
        end
        S_DRAIN: if (!s1_vld) begin
          max_q <= acc;
          state <= S_HOLD;
        end
        default: if (max_exp_ready) begin
          acc   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prob_node_max_exp.sv
module tb_prob_node_max_exp;
  localparam int LANES = 8;
  localparam int DW    = 16;
  localparam int EW    = 8;
  localparam int LW    = 11;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [1:0]          mode = 2'b00;
  logic [LW-1:0]       lines_minus1 = '0;
  logic [LANES*DW-1:0] in_data = '0;
  logic                in_vld = 1'b0;
  logic                in_ready;
  logic [EW-1:0]       max_exp;
  logic                max_exp_vld;
  logic                max_exp_ready = 1'b0;
`ifdef MAX_EXP_MIN_TRACK_EN
  logic [EW-1:0]       min_exp;
`endif

  prob_node_max_exp #(.LANES(LANES), .DW(DW), .EW(EW), .LW(LW)) dut (
    .clk           (clk),
    .rst           (rst),
    .mode          (mode),
    .lines_minus1  (lines_minus1),
    .in_data       (in_data),
    .in_vld        (in_vld),
    .in_ready      (in_ready),
    .max_exp       (max_exp),
    .max_exp_vld   (max_exp_vld),
    .max_exp_ready (max_exp_ready)
`ifdef MAX_EXP_MIN_TRACK_EN
    ,
    .min_exp       (min_exp)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          errors = 0;
  int          checks = 0;
  int unsigned last_acc = 0;
  logic [EW-1:0] q_max [$];
  logic [EW-1:0] q_min [$];
  logic [1:0]    node_mode;
  logic [EW-1:0] node_max;
  logic [EW-1:0] node_min;
  logic          node_seen;
  logic [LANES*DW-1:0] d;
  logic [LANES*DW-1:0] bubble;

  function automatic logic [7:0] exp_of(input logic [1:0] m, input logic [15:0] w);
    case (m)
      2'b01:   return {3'b000, w[14:10]};
      2'b10:   return w[7:0];
      default: return w[14:7];
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic start_node(input logic [1:0] m, input logic [LW-1:0] lm1);
    mode         = m;
    lines_minus1 = lm1;
    node_mode    = m;
    node_max     = '0;
    node_min     = '1;
    node_seen    = 1'b0;
  endtask

  task automatic send_beat(input logic [LANES*DW-1:0] v);
    int n;
    in_data = v;
    in_vld  = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    chk("beat_ready", in_ready, 1);
    tick();
    last_acc = cyc;
    in_vld   = 1'b0;
  endtask

  task automatic beat(input logic [LANES*DW-1:0] v);
    logic [7:0] e;
    send_beat(v);
    for (int i = 0; i < LANES; i++) begin
      e = exp_of(node_mode, v[i*DW +: DW]);
      if (e > node_max) node_max = e;
      if (e != 0) begin
        node_seen = 1'b1;
        if (e < node_min) node_min = e;
      end
    end
  endtask

  task automatic end_node();
    q_max.push_back(node_max);
    q_min.push_back(node_seen ? node_min : '0);
  endtask

  task automatic wait_vld(input string tag);
    int n;
    n = 0;
    while (!max_exp_vld && n < 64) begin
      tick();
      n++;
    end
    chk({tag, "_vld"}, max_exp_vld, 1);
    chk({tag, "_latency"}, cyc - last_acc, 2);
  endtask

  task automatic handshake(input string tag);
    logic [EW-1:0] em;
    logic [EW-1:0] en;
    chk({tag, "_queue"}, q_max.size(), 1);
    em = (q_max.size() > 0) ? q_max.pop_front() : '0;
    en = (q_min.size() > 0) ? q_min.pop_front() : '0;
    chk({tag, "_max"}, max_exp, em);
`ifdef MAX_EXP_MIN_TRACK_EN
    chk({tag, "_min"}, min_exp, en);
`endif
    chk({tag, "_busy"}, in_ready, 0);
    max_exp_ready = 1'b1;
    tick();
    max_exp_ready = 1'b0;
    chk({tag, "_held"}, max_exp, em);
    chk({tag, "_vld_low"}, max_exp_vld, 0);
    chk({tag, "_ready_back"}, in_ready, 1);
  endtask

  initial begin
    for (int i = 0; i < LANES; i++) bubble[i*DW +: DW] = 16'h7F80;

    // reset
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_vld", max_exp_vld, 0);
    chk("rst_max", max_exp, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // single-line node
    start_node(2'b00, 0);
    d = '0;
    d[0*DW +: DW] = 16'h3F80;
    d[1*DW +: DW] = 16'h4000;
    beat(d);
    end_node();
    chk("single_drain_ready", in_ready, 0);
    tick();
    chk("single_early_vld", max_exp_vld, 0);
    wait_vld("single");
    handshake("single");

    // 256-line node with bubbles carrying large exponents
    start_node(2'b00, 255);
    for (int l = 0; l < 256; l++) begin
      for (int i = 0; i < LANES; i++) d[i*DW +: DW] = 16'($urandom_range(0, 16'h4000));
      if (l == 200) d[5*DW +: DW] = 16'h7F00;
      beat(d);
      in_data = bubble;
      tick();
    end
    end_node();
    wait_vld("long");
    handshake("long");

    // fp16 node, mode and length changed after the first beat
    start_node(2'b01, 3);
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < LANES; i++) d[i*DW +: DW] = 16'h3C00;
      if (l == 2) d[3*DW +: DW] = 16'h7BFF;
      beat(d);
      mode         = 2'b10;
      lines_minus1 = 1;
    end
    end_node();
    wait_vld("fp16");
    handshake("fp16");

    // backpressure
    start_node(2'b00, 1);
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < LANES; i++) d[i*DW +: DW] = 16'($urandom_range(0, 16'h4000));
      if (l == 1) d[6*DW +: DW] = 16'h5500;
      beat(d);
    end
    end_node();
    wait_vld("bp");
    for (int k = 0; k < 20; k++) begin
      in_vld  = 1'b1;
      in_data = bubble;
      chk("bp_vld", max_exp_vld, 1);
      chk("bp_stable", max_exp, q_max[0]);
      chk("bp_no_accept", in_ready, 0);
      tick();
    end
    in_vld = 1'b0;
    handshake("bp");
    start_node(2'b00, 0);
    d = '0;
    d[2*DW +: DW] = 16'h0080;
    beat(d);
    end_node();
    wait_vld("after_bp");
    handshake("after_bp");

    // reset in the middle of a node
    start_node(2'b00, 255);
    for (int l = 0; l < 100; l++) begin
      d = '0;
      if (l == 50) d[0] = 1'b0;
      if (l == 50) d[0*DW +: DW] = 16'h7F00;
      beat(d);
    end
    rst = 1'b0;
    #1;
    chk("midrst_ready", in_ready, 1);
    chk("midrst_vld", max_exp_vld, 0);
    chk("midrst_max", max_exp, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) tick();
    chk("midrst_no_result", max_exp_vld, 0);
    start_node(2'b00, 1);
    d = '0;
    d[4*DW +: DW] = 16'h0080;
    beat(d);
    d = '0;
    d[7*DW +: DW] = 16'h00FF;
    beat(d);
    end_node();
    wait_vld("post_rst");
    handshake("post_rst");

    // all-zero node
    start_node(2'b00, 2);
    for (int l = 0; l < 3; l++) beat('0);
    end_node();
    wait_vld("zero");
    handshake("zero");

    // min/max mix
    start_node(2'b00, 1);
    d = '0;
    d[1*DW +: DW] = 16'h3F00;
    beat(d);
    d = '0;
    d[0*DW +: DW] = 16'h4800;
    beat(d);
    end_node();
    wait_vld("minmax");
    handshake("minmax");

    // raw mode and reserved mode
    start_node(2'b10, 1);
    for (int i = 0; i < LANES; i++) d[i*DW +: DW] = 16'h7F12;
    d[2*DW +: DW] = 16'h00C3;
    beat(d);
    beat(d);
    end_node();
    wait_vld("raw");
    handshake("raw");
    start_node(2'b11, 0);
    d = '0;
    d[3*DW +: DW] = 16'h4000;
    d[4*DW +: DW] = 16'h03FF;
    beat(d);
    end_node();
    wait_vld("rsvd");
    handshake("rsvd");

    // full-length node: 2^LW beats
    start_node(2'b00, 11'h7FF);
    for (int l = 0; l < 2048; l++) begin
      d = '0;
      if (l == 2047) d[7*DW +: DW] = 16'h7F80;
      beat(d);
    end
    end_node();
    wait_vld("full");
    handshake("full");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
